snn_layer_tdm: RTL and testbench
================================

# snn_layer_tdm

Time-multiplexed leaky-integrate-and-fire layer: one shared update datapath serially evaluates NUM_NEURONS neurons per accepted input sample, with potentials and refractory counters held in internal register arrays. It is the parametrised successor to the per-neuron-instance array. It adds a valid/ready input handshake, signed saturating potentials, a selectable post-spike reset mode and per-neuron refractory periods. It sits between the pixel/encoder stream and the spike-readout/classifier logic.

## Interface
- DATA_WIDTH, 8: unsigned input sample width
- NUM_NEURONS, 10: neurons in layer (>=1)
- POT_WIDTH, 16: signed membrane potential width
- RESET_MODE, 0: 0 = reset potential to zero on fire; 1 = subtract threshold
- REFRACT_STEPS, 0: samples a neuron ignores after firing (0 = none)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pixel_in  in  DATA_WIDTH  input sample
- pixel_valid  in  1  sample valid
- pixel_ready  out  1  block can accept a sample
- weights_all  in  [NUM_NEURONS][16]  signed per-neuron weight
- decays_all  in  [NUM_NEURONS][4]  per-neuron leak shift (0 = no leak)
- thresh_all  in  [NUM_NEURONS][POT_WIDTH]  signed per-neuron threshold
- enables_in  in  NUM_NEURONS  per-neuron enable
- clear_in  in  1  synchronous clear of all neuron state
- spikes_out  out  NUM_NEURONS  spike vector for the last completed sample
- spikes_valid  out  1  one-cycle strobe qualifying spikes_out

## Operation
- The FSM has three states: IDLE, UPDATE and DONE.
  - IDLE: pixel_ready=1. When pixel_valid is high, the block latches pixel_in, clears idx, clears the spike accumulator and goes to UPDATE.
  - UPDATE: processes neuron idx in one cycle. idx runs 0..NUM_NEURONS-1. After the last neuron the FSM goes to DONE.
  - DONE: copies the accumulator to spikes_out, pulses spikes_valid and returns to IDLE.
- Per-neuron update for neuron i with enable=1 and refractory count 0:
  - leak = V >>> decays_all[i] when the shift is nonzero, otherwise 0.
  - sum = V − leak + pixel×weight. pixel is zero-extended, the product is signed, and the sum is computed at full width (POT_WIDTH+DATA_WIDTH+17 bits).
  - Vn = sum saturated to [−2^(POT_WIDTH−1), 2^(POT_WIDTH−1)−1].
  - The neuron fires if Vn ≥ thresh_all[i] (signed compare).
  - On fire: V = 0 (RESET_MODE 0) or Vn − thresh, saturated (RESET_MODE 1). The spike bit is set and the refractory count is loaded with REFRACT_STEPS.
  - Otherwise V = Vn.
- A neuron with a nonzero refractory count does not integrate. Its V is held, its spike bit is 0 and its count decrements by 1.
- A disabled neuron does not change: V and the count are held and its spike bit is 0.
- Configuration inputs are sampled in the cycle neuron i is updated. They must be stable while pixel_ready=0.
- clear_in takes priority over everything in any state. It zeroes all V, all refractory counts and spikes_out, returns the FSM to IDLE and suppresses spikes_valid. A sample being processed is discarded.
- A spike output is registered and holds until the next DONE, a clear or a reset.

## Timing
- Sample accepted at edge t (pixel_valid && pixel_ready).
- UPDATE occupies cycles t+1..t+NUM_NEURONS.
- spikes_valid is high for exactly the cycle after edge t+NUM_NEURONS+1.
- Throughput is one sample per NUM_NEURONS+2 cycles.
- pixel_ready is low from the cycle after acceptance until the FSM is back in IDLE.
- A sample held valid in the DONE→IDLE cycle is accepted on the next edge.
- The reset value of every output is 0: pixel_ready=0, spikes_out=0, spikes_valid=0. Reset also zeroes all V and counts and puts the FSM in IDLE.
- pixel_ready goes to 1 on the first edge after rst is released.
- Reset asserted mid-UPDATE clears state immediately (asynchronous). No spikes_valid is produced for that sample.

## Test plan
Common settings: NUM_NEURONS=4, DATA_WIDTH=8, POT_WIDTH=16, RESET_MODE=0 unless noted.
- Integrate and fire: neuron0 with w=10, thresh=100, decay=0; two samples of 5 → V=50, no spike; then V=100, spikes_out=4'b0001, V=0.
- Leak: w=1, decay=1, thresh=1000; samples of 64 → V=64, 96, 112, 120. No spike at any step.
- Saturation: w=32767, pixel=255, thresh=32767, RESET_MODE=1 → Vn saturates to 32767 and the neuron fires, then V=0. With w=−32768 → V=−32768 and no spike.
- Refractory: REFRACT_STEPS=2, w=50, thresh=100, samples of 1 → fire on sample 2; samples 3 and 4 ignored with V=0 held; V=50 after sample 5.
- Handshake: pixel_valid held high continuously → accepts every 6 cycles; spikes_valid is a 1-cycle pulse at acceptance+5; pixel_ready=0 during busy; enables_in=4'b1010 keeps neurons 0 and 2 at V=0.
- Clear and reset: clear_in during UPDATE idx=2 → all V=0, no spikes_valid, FSM in IDLE next cycle. rst asserted mid-UPDATE → all outputs 0 immediately.

Source files
------------

// File: rtl/snn_layer_tdm.sv
// snn_layer_tdm: time-multiplexed LIF layer, one shared datapath updates one neuron per cycle
module snn_layer_tdm #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_NEURONS   = 10,
    parameter int POT_WIDTH     = 16,
    parameter int RESET_MODE    = 0,
    parameter int REFRACT_STEPS = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH-1:0]                 pixel_in,
    input  logic                                  pixel_valid,
    output logic                                  pixel_ready,
    input  logic [NUM_NEURONS-1:0][15:0]          weights_all,
    input  logic [NUM_NEURONS-1:0][3:0]           decays_all,
    input  logic [NUM_NEURONS-1:0][POT_WIDTH-1:0] thresh_all,
    input  logic [NUM_NEURONS-1:0]                enables_in,
    input  logic                                  clear_in,
    output logic [NUM_NEURONS-1:0]                spikes_out,
    output logic                                  spikes_valid
);
    localparam int SW = POT_WIDTH + DATA_WIDTH + 17;
    localparam int IW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
    localparam int RW = REFRACT_STEPS > 0 ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam logic signed [POT_WIDTH-1:0] MAXP = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] MINP = {1'b1, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = MAXP;
    localparam logic signed [SW-1:0] MINV = MINP;

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                         r_state, w_next;
    logic [DATA_WIDTH-1:0]          r_pixel;
    logic [IW-1:0]                  r_idx;
    logic [NUM_NEURONS-1:0]         r_acc;
    logic signed [POT_WIDTH-1:0]    r_v [NUM_NEURONS];
    logic [RW-1:0]                  r_cnt [NUM_NEURONS];
    logic                           r_ready;

    logic                           w_accept, w_update, w_done, w_last, w_act, w_fire;
    logic signed [POT_WIDTH-1:0]    w_v, w_th, w_vn, w_vr, w_vnew;
    logic signed [15:0]             w_w;
    logic [3:0]                     w_d;
    logic signed [SW-1:0]           w_ve, w_le, w_pe, w_sum;
    logic signed [POT_WIDTH:0]      w_sub;

    // state register; clear returns to IDLE from any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (clear_in)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state == IDLE   ? (w_accept ? UPDATE : IDLE) :
                 r_state == UPDATE ? (w_last ? DONE : UPDATE) : IDLE;
    end

    // FSM decode
    always_comb begin
        w_accept    = r_state == IDLE && r_ready && pixel_valid;
        w_update    = r_state == UPDATE;
        w_done      = r_state == DONE;
        w_last      = r_idx == IW'(NUM_NEURONS - 1);
        pixel_ready = r_ready;
    end

    // shared neuron datapath for the neuron selected by r_idx
    always_comb begin
        w_v   = r_v[r_idx];
        w_w   = weights_all[r_idx];
        w_d   = decays_all[r_idx];
        w_th  = thresh_all[r_idx];
        w_act = enables_in[r_idx] && r_cnt[r_idx] == '0;
        w_ve  = w_v;
        w_le  = '0;
        if (w_d != 4'd0)
            w_le = w_v >>> w_d;
        w_pe  = $signed({1'b0, r_pixel}) * w_w;
        w_sum = w_ve - w_le + w_pe;
        w_vn  = w_sum > MAXV ? MAXP : w_sum < MINV ? MINP : w_sum[POT_WIDTH-1:0];
        w_fire = w_vn >= w_th;
        w_sub = w_vn - w_th;
        w_vr  = w_sub > MAXP ? MAXP : w_sub < MINP ? MINP : w_sub[POT_WIDTH-1:0];
        w_vnew = RESET_MODE == 1 ? w_vr : '0;
    end

    // neuron state, sample latch, index and spike accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear_in) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i]   <= '0;
                r_cnt[i] <= '0;
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_pixel <= '0;
        end else if (w_accept) begin
            r_pixel <= pixel_in;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (w_update) begin
            if (w_act) begin
                r_v[r_idx] <= w_fire ? w_vnew : w_vn;
                if (w_fire)
                    r_cnt[r_idx] <= RW'(REFRACT_STEPS);
                r_acc[r_idx] <= w_fire;
            end else begin
                if (enables_in[r_idx])
                    r_cnt[r_idx] <= r_cnt[r_idx] - RW'(1);
                r_acc[r_idx] <= 1'b0;
            end
            r_idx <= r_idx + IW'(1);
        end
    end

    // registered outputs: ready tracks the next state, spikes publish on DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready      <= 1'b0;
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
        end else if (clear_in) begin
            r_ready      <= 1'b1;
            spikes_out   <= '0;
            spikes_valid <= 1'b0;
        end else begin
            r_ready      <= w_next == IDLE;
            spikes_valid <= w_done;
            if (w_done)
                spikes_out <= r_acc;
        end
    end
endmodule

// File: tb/tb_snn_layer_tdm.sv
// tb_snn_layer_tdm: directed and random checks of two layer configurations against a behavioural model
module tb_snn_layer_tdm;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pixel_in = '0;
    logic pixel_valid = 1'b0;
    logic clear_in = 1'b0;
    logic [N-1:0][15:0] weights_all;
    logic [N-1:0][3:0] decays_all;
    logic [N-1:0][15:0] thresh_all;
    logic [N-1:0] enables_in;
    logic rdy0, rdy1, sv0, sv1;
    logic [N-1:0] so0, so1;

    int checks = 0;
    int errors = 0;
    int w[N], th[N], d[N];
    logic [N-1:0] en;
    longint mv[2][N];
    int mc[2][N];
    logic [N-1:0] ms[2];
    logic [5:0] ref_pat1, ref_pat0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            weights_all[i] = 16'(w[i]);
            decays_all[i]  = 4'(d[i]);
            thresh_all[i]  = 16'(th[i]);
        end
        enables_in = en;
    end

    snn_layer_tdm #(.DATA_WIDTH(8), .NUM_NEURONS(N), .POT_WIDTH(16), .RESET_MODE(0), .REFRACT_STEPS(0)) dut0 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(rdy0),
        .weights_all(weights_all), .decays_all(decays_all), .thresh_all(thresh_all),
        .enables_in(enables_in), .clear_in(clear_in), .spikes_out(so0), .spikes_valid(sv0));

    snn_layer_tdm #(.DATA_WIDTH(8), .NUM_NEURONS(N), .POT_WIDTH(16), .RESET_MODE(1), .REFRACT_STEPS(2)) dut1 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(rdy1),
        .weights_all(weights_all), .decays_all(decays_all), .thresh_all(thresh_all),
        .enables_in(enables_in), .clear_in(clear_in), .spikes_out(so1), .spikes_valid(sv1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = '0;
            for (int i = 0; i < N; i++) begin
                mv[k][i] = 0;
                mc[k][i] = 0;
            end
        end
    endtask

    // model 0: reset-to-zero, no refractory; model 1: subtract threshold, 2 refractory samples
    task automatic model_step(input int px);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!en[i]) begin
                    ms[k][i] = 1'b0;
                end else if (mc[k][i] > 0) begin
                    mc[k][i]--;
                    ms[k][i] = 1'b0;
                end else begin
                    longint lk, vn;
                    lk = d[i] != 0 ? (mv[k][i] >>> d[i]) : 0;
                    vn = sat(mv[k][i] - lk + longint'(px) * w[i]);
                    if (vn >= th[i]) begin
                        ms[k][i] = 1'b1;
                        mv[k][i] = k == 1 ? sat(vn - th[i]) : 0;
                        mc[k][i] = k == 1 ? 2 : 0;
                    end else begin
                        ms[k][i] = 1'b0;
                        mv[k][i] = vn;
                    end
                end
            end
        end
    endtask

    task automatic send(input int px);
        int n;
        logic busy_bad;
        busy_bad = 1'b0;
        pixel_in = 8'(px);
        pixel_valid = 1'b1;
        n = 0;
        while (!(rdy0 && rdy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", {31'd0, rdy0 & rdy1}, 1);
        @(negedge clk);
        pixel_valid = 1'b0;
        model_step(px);
        n = 0;
        while (!sv0 && n < 20) begin
            if (rdy0 || rdy1) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("latency", n, 5);
        chk("busy_ready_low", {31'd0, busy_bad}, 0);
        chk("sv1_with_sv0", {31'd0, sv1}, 1);
        chk("spikes0", {28'd0, so0}, {28'd0, ms[0]});
        chk("spikes1", {28'd0, so1}, {28'd0, ms[1]});
        chk("ready_at_done", {31'd0, rdy0}, 1);
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, sv0 | sv1}, 0);
        chk("spikes_hold", {28'd0, so0}, {28'd0, ms[0]});
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        model_reset();
        chk("clear_spikes", {28'd0, so0 | so1}, 0);
        chk("clear_ready", {31'd0, rdy0 & rdy1}, 1);
    endtask

    task automatic cfg(input int i, input int wi, input int ti, input int di);
        w[i] = wi;
        th[i] = ti;
        d[i] = di;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) cfg(i, 0, 0, 0);
        en = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, rdy0 | rdy1}, 0);
        chk("rst_spikes", {28'd0, so0 | so1}, 0);
        chk("rst_valid", {31'd0, sv0 | sv1}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, rdy0 & rdy1}, 1);

        en = 4'b0001;
        cfg(0, 10, 100, 0);
        for (int i = 1; i < N; i++) cfg(i, 0, 1000, 0);
        send(5);
        chk("if_first", {28'd0, so0}, 0);
        send(5);
        chk("if_fire0", {28'd0, so0}, 1);
        chk("if_fire1", {28'd0, so1}, 1);

        do_clear();
        cfg(0, 50, 100, 0);
        ref_pat1 = 6'b100010;
        ref_pat0 = 6'b101010;
        for (int s = 0; s < 6; s++) begin
            send(1);
            chk("refr_m1", {31'd0, so1[0]}, {31'd0, ref_pat1[s]});
            chk("refr_m0", {31'd0, so0[0]}, {31'd0, ref_pat0[s]});
        end

        do_clear();
        cfg(0, 1, 1000, 1);
        for (int s = 0; s < 4; s++) begin
            send(64);
            chk("leak_nospike", {28'd0, so0 | so1}, 0);
        end
        cfg(0, 1, 124, 1);
        send(64);
        chk("leak_ge_fire", {31'd0, so0[0] & so1[0]}, 1);

        do_clear();
        cfg(0, 32767, 32767, 0);
        send(255);
        chk("sat_hi_fire", {31'd0, so0[0] & so1[0]}, 1);
        do_clear();
        cfg(0, -32768, 32767, 0);
        send(255);
        chk("sat_lo_nofire", {28'd0, so0 | so1}, 0);
        cfg(0, 0, -32768, 0);
        send(0);
        chk("sat_lo_fire", {31'd0, so0[0] & so1[0]}, 1);

        do_clear();
        en = 4'b1010;
        for (int i = 0; i < N; i++) cfg(i, 40, 100, 0);
        pixel_in = 8'd2;
        pixel_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            model_step(2);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!sv0 && n < 20);
            if (s == 2) pixel_valid = 1'b0;
            chk("period", n, 6);
            chk("held_spk0", {28'd0, so0}, {28'd0, ms[0]});
            chk("held_spk1", {28'd0, so1}, {28'd0, ms[1]});
            chk("disabled_quiet", {28'd0, (so0 | so1) & 4'b0101}, 0);
        end
        @(negedge clk);
        chk("held_pulse_end", {31'd0, sv0 | sv1}, 0);

        for (int s = 0; s < 30; s++) begin
            en = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                cfg(i, int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 3000)) - 500,
                    int'($urandom_range(0, 4)));
                if ($urandom_range(0, 7) == 0) w[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            end
            send(int'($urandom_range(0, 255)));
        end

        pixel_in = 8'd9;
        pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        model_reset();
        chk("mid_clear_ready", {31'd0, rdy0 & rdy1}, 1);
        chk("mid_clear_spikes", {28'd0, so0 | so1}, 0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (sv0 || sv1) n++;
            @(negedge clk);
        end
        chk("mid_clear_no_valid", n, 0);
        en = 4'b1111;
        for (int i = 0; i < N; i++) cfg(i, 3, 20, 0);
        send(4);
        send(4);

        pixel_valid = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_ready", {31'd0, rdy0 | rdy1}, 0);
        chk("async_rst_spikes", {28'd0, so0 | so1}, 0);
        chk("async_rst_valid", {31'd0, sv0 | sv1}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sv0 || sv1) n++;
        end
        chk("rst_no_valid", n, 0);
        send(4);
        send(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
